// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pool window scheduler.
package pool_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_NUM = 16;
  localparam int ADDR_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_MERGE = 3'd2,
    ST_RD_A  = 3'd3,
    ST_RD_B  = 3'd4,
    ST_RES   = 3'd5,
    ST_OUT   = 3'd6
  } state_t;

  // A job is runnable when the row is non-empty, even, fits the register
  // file, and at least one row pair is requested.
  function automatic logic cfg_ok(input logic [4:0] width,
                                  input logic [7:0] rows,
                                  input int         reg_num);
    return (width != 5'd0) && !width[0] && (int'(width) <= reg_num) &&
           (rows != 8'd0);
  endfunction

endpackage

// File: rtl/pool_max2.sv
// Signed two-input maximum, purely combinational.
module pool_max2 #(
  parameter int DATA_W = pool_pkg::DATA_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] y
);

  assign y = (a > b) ? a : b;

endmodule

// File: rtl/pool_window_sched.sv
// 2x2 max-pool scheduler: buffers the top row of each row pair in an
// external register file, then merges it with the bottom row beat by beat.
module pool_window_sched #(
  parameter int DATA_W  = pool_pkg::DATA_W,
  parameter int REG_NUM = pool_pkg::REG_NUM,
  parameter int ADDR_W  = pool_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     start,
  input  logic [4:0]               cfg_width,
  input  logic [7:0]               cfg_rows,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_pix0,
  input  logic signed [DATA_W-1:0] in_pix1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     rf_wr_ctrl,
  output logic signed [DATA_W-1:0] rf_in1,
  output logic signed [DATA_W-1:0] rf_in2,
  output logic [ADDR_W-1:0]        rf_adrs_in1,
  output logic [ADDR_W-1:0]        rf_adrs_in2,
  output logic [ADDR_W-1:0]        rf_adrs_out,
  input  logic signed [DATA_W-1:0] rf_out
);

  import pool_pkg::*;

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          k_q, k_d;
  logic [7:0]                 row_q, row_d;
  logic [4:0]                 cfg_width_q, cfg_width_d;
  logic [7:0]                 cfg_rows_q, cfg_rows_d;
  logic signed [DATA_W-1:0]   maxb_q, maxb_d;
  logic signed [DATA_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]   out_data_q, out_data_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic signed [DATA_W-1:0]   max_a, max_b, max_y;
  logic [ADDR_W-1:0]          last_k;
  logic                       k_last, row_last, fill_wr;
  logic [ADDR_W-1:0]          adr_even, adr_odd;

  assign last_k   = ADDR_W'(cfg_width_q[4:1]) - ADDR_W'(1);
  assign k_last   = (k_q == last_k);
  assign row_last = (row_q == cfg_rows_q - 8'd1);
  assign adr_even = {k_q[ADDR_W-2:0], 1'b0};
  assign adr_odd  = {k_q[ADDR_W-2:0], 1'b1};
  assign fill_wr  = (state_q == ST_FILL) && in_valid;

  // One comparator serves all three max steps; the state picks its operands.
  always_comb begin
    max_a = '0;
    max_b = '0;
    case (state_q)
      ST_MERGE: begin max_a = in_pix0; max_b = in_pix1; end
      ST_RD_B:  begin max_a = maxb_q;  max_b = rf_out;  end
      ST_RES:   begin max_a = acc_q;   max_b = rf_out;  end
      default:  ;
    endcase
  end

  pool_max2 #(.DATA_W(DATA_W)) u_max (
    .a (max_a),
    .b (max_b),
    .y (max_y)
  );

  // Next-state logic for the job sequencer and its datapath registers.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d     = state_q;
    k_d         = k_q;
    row_d       = row_q;
    cfg_width_d = cfg_width_q;
    cfg_rows_d  = cfg_rows_q;
    maxb_d      = maxb_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok(cfg_width, cfg_rows, REG_NUM)) begin
            cfg_width_d = cfg_width;
            cfg_rows_d  = cfg_rows;
            k_d         = '0;
            row_d       = '0;
            state_d     = ST_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (in_valid) begin
          if (k_last) begin
            k_d     = '0;
            state_d = ST_MERGE;
          end else begin
            k_d = k_q + ADDR_W'(1);
          end
        end
      end
      ST_MERGE: begin
        if (in_valid) begin
          maxb_d  = max_y;
          state_d = ST_RD_A;
        end
      end
      ST_RD_A: state_d = ST_RD_B;
      ST_RD_B: begin
        acc_d   = max_y;
        state_d = ST_RES;
      end
      ST_RES: begin
        out_data_d = max_y;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          if (!k_last) begin
            k_d     = k_q + ADDR_W'(1);
            state_d = ST_MERGE;
          end else if (!row_last) begin
            k_d     = '0;
            row_d   = row_q + 8'd1;
            state_d = ST_FILL;
          end else begin
            k_d     = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: all control and datapath flops are reset so an aborted job
    // leaves nothing behind; the register file is external and not reset.
    if (!nrst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      row_q       <= '0;
      cfg_width_q <= '0;
      cfg_rows_q  <= '0;
      maxb_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      k_q         <= k_d;
      row_q       <= row_d;
      cfg_width_q <= cfg_width_d;
      cfg_rows_q  <= cfg_rows_d;
      maxb_q      <= maxb_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Read address walks the buffered top-row pixels of the current beat.
  always_comb begin
    rf_adrs_out = '0;
    case (state_q)
      ST_RD_A: rf_adrs_out = adr_even;
      ST_RD_B: rf_adrs_out = adr_odd;
      default: ;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign in_ready    = (state_q == ST_FILL) || (state_q == ST_MERGE);
  assign out_valid   = (state_q == ST_OUT);
  assign out_data    = out_data_q;
  assign out_last    = out_valid && k_last && row_last;
  assign rf_wr_ctrl  = fill_wr;
  assign rf_in1      = fill_wr ? in_pix0 : '0;
  assign rf_in2      = fill_wr ? in_pix1 : '0;
  assign rf_adrs_in1 = fill_wr ? adr_even : '0;
  assign rf_adrs_in2 = fill_wr ? adr_odd : '0;

endmodule
